wb_slave_pipelined: RTL and testbench

WB_SLAVE_PIPELINED -- requirements
Module: wb_slave_pipelined

---
 rtl/wb_slave_pipelined_if.sv | 14 +
 rtl/wb_slave_pipelined.sv | 104 ++++++++++
 tb/tb_wb_slave_pipelined.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/wb_slave_pipelined_if.sv
// Wishbone B4 pipelined bus bundle (16-bit address and data) shared by master and slave.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] dat_m;
  logic [15:0] dat_s;
  logic        ack;
  logic        stall;

  modport master (output cyc, stb, we, adr, dat_m, input dat_s, ack, stall);
  modport slave  (input cyc, stb, we, adr, dat_m, output dat_s, ack, stall);
endinterface

// File: rtl/wb_slave_pipelined.sv
// Pipelined Wishbone slave in front of a 256 x 16 RAM, with an optional number of
// stall cycles inserted after every accepted request.
//
//   state | meaning
//   IDLE  | no pending request, stall=0
//   WAIT  | request pending, stall=1, wait down-counter running
//   ACK   | ack=1 for the pending request, stall=0, may accept the next one
module wb_slave_pipelined #(
  parameter int waitcycles = 0
) (
  input  logic clk,
  input  logic rst,
  if_wb.slave  wb
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [3:0] cnt_load = (waitcycles > 0) ? 4'(waitcycles - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] mem [256];
  logic [15:0] mem_rd;
  logic [15:0] rd_buf;
  logic [15:0] dat_s_q;
  logic        pend_rd;
  logic        ack_q;
  logic        stall_q;
  logic        accept;
  logic        adr_unused;

  assign adr_unused = ^wb.adr[15:8];
  assign mem_rd     = mem[wb.adr[7:0]];
  assign accept     = wb.cyc & wb.stb & ~stall_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (waitcycles > 0) ? WAIT : ACK;
          cnt_nxt   = cnt_load;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = ACK;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ACK: begin
        if (accept) begin
          state_nxt = (waitcycles > 0) ? WAIT : ACK;
          cnt_nxt   = cnt_load;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Dropping cyc aborts whatever is in flight.
    if (!wb.cyc) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      dat_s_q <= 16'h0000;
      rd_buf  <= 16'h0000;
      pend_rd <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ack_q   <= (state_nxt == ACK);
      stall_q <= (state_nxt == WAIT);
      if (accept) begin
        pend_rd <= ~wb.we;
        rd_buf  <= mem_rd;
      end
      // dat_s only changes on entry to an ack cycle, so it holds otherwise.
      if (state_nxt == ACK) begin
        if (waitcycles == 0) begin
          if (accept && !wb.we) dat_s_q <= mem_rd;
        end else if (pend_rd) begin
          dat_s_q <= rd_buf;
        end
      end
    end
  end

  // RAM is deliberately outside the reset domain so its contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && accept && wb.we) mem[wb.adr[7:0]] <= wb.dat_m;
  end

  // A master dropping cyc in the ack cycle never sees a stray ack.
  assign wb.ack   = ack_q & wb.cyc;
  assign wb.stall = stall_q;
  assign wb.dat_s = dat_s_q;
endmodule

// File: tb/tb_wb_slave_pipelined.sv
// Directed bench for wb_slave_pipelined: three instances (waitcycles 0, 1, 3) share
// one set of master drives, gated by sel, with a cycle-exact expected ack/stall model.
module tb_wb_slave_pipelined;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [15:0] adr = 16'h0;
  logic [15:0] dat_m = 16'h0;
  int          sel = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        ack, stall;
  logic [15:0] dat_s;

  if_wb bus0 ();
  if_wb bus1 ();
  if_wb bus2 ();

  assign bus0.cyc = cyc && (sel == 0);
  assign bus1.cyc = cyc && (sel == 1);
  assign bus2.cyc = cyc && (sel == 2);
  assign bus0.stb = stb;  assign bus1.stb = stb;  assign bus2.stb = stb;
  assign bus0.we = we;    assign bus1.we = we;    assign bus2.we = we;
  assign bus0.adr = adr;  assign bus1.adr = adr;  assign bus2.adr = adr;
  assign bus0.dat_m = dat_m;  assign bus1.dat_m = dat_m;  assign bus2.dat_m = dat_m;

  assign ack   = (sel == 0) ? bus0.ack   : (sel == 1) ? bus1.ack   : bus2.ack;
  assign stall = (sel == 0) ? bus0.stall : (sel == 1) ? bus1.stall : bus2.stall;
  assign dat_s = (sel == 0) ? bus0.dat_s : (sel == 1) ? bus1.dat_s : bus2.dat_s;

  wb_slave_pipelined #(.waitcycles(0)) dut0 (.clk(clk), .rst(rst), .wb(bus0));
  wb_slave_pipelined #(.waitcycles(1)) dut1 (.clk(clk), .rst(rst), .wb(bus1));
  wb_slave_pipelined #(.waitcycles(3)) dut2 (.clk(clk), .rst(rst), .wb(bus2));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (sel=%0d t=%0t): got %h expected %h", tag, sel, $time, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge with the bus idle.
  task automatic burst(input int n, input bit wr, input logic [15:0] a0,
                       input logic [15:0] d0, input logic [15:0] e0, input int nw);
    int acc;
    int p;
    bit exp_stall;
    bit exp_ack;
    acc = 0;
    p = nw + 1;
    for (int c = 0; c <= n * p; c++) begin
      cyc   = 1'b1;
      stb   = (acc < n);
      we    = wr;
      adr   = a0 + 16'(acc);
      dat_m = d0 + 16'(acc);
      @(negedge clk);
      exp_stall = (c % p) != 0;
      exp_ack   = (c > 0) && ((c % p) == 0);
      check_val("stall", {15'b0, stall}, {15'b0, exp_stall});
      check_val("ack", {15'b0, ack}, {15'b0, exp_ack});
      if (exp_ack && !wr) check_val("rdata", dat_s, e0 + 16'(c / p - 1));
      if (stb && !exp_stall) acc++;
      @(posedge clk); #1;
    end
    cyc = 1'b0;
    stb = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check_val("rst_ack", {15'b0, ack}, 16'h0);
      check_val("rst_stall", {15'b0, stall}, 16'h0);
      check_val("rst_dat_s", dat_s, 16'h0000);
    end
    sel = 0;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 1; i <= 10; i++) burst(1, 1'b1, 16'(i), 16'(100 + i), 16'h0, 0);
    for (int i = 1; i <= 10; i++) burst(1, 1'b0, 16'(i), 16'h0, 16'(100 + i), 0);

    burst(1, 1'b1, 16'h0130, 16'h1234, 16'h0, 0);
    burst(1, 1'b0, 16'hFF30, 16'h0, 16'h1234, 0);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      burst(10, 1'b1, 16'd11, 16'd211, 16'h0, (s == 0) ? 0 : (s == 1) ? 1 : 3);
      burst(10, 1'b0, 16'd11, 16'h0, 16'd211, (s == 0) ? 0 : (s == 1) ? 1 : 3);
    end

    // Abort: cyc dropped one cycle after a read is accepted (waitcycles=3).
    sel = 2;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'd12;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check_val("abort_stall1", {15'b0, stall}, 16'h1);
    check_val("abort_ack1", {15'b0, ack}, 16'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("abort_ack", {15'b0, ack}, 16'h0);
      check_val("abort_stall", {15'b0, stall}, 16'h0);
    end
    @(posedge clk); #1;
    burst(1, 1'b0, 16'd11, 16'h0, 16'd211, 3);

    // Reset mid-transaction, with a write presented during reset that must not land.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'd12;
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b1; adr = 16'd16; dat_m = 16'hDEAD;
    @(negedge clk);
    check_val("pre_rst_stall", {15'b0, stall}, 16'h1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_val("mid_rst_ack", {15'b0, ack}, 16'h0);
      check_val("mid_rst_stall", {15'b0, stall}, 16'h0);
      check_val("mid_rst_dat_s", dat_s, 16'h0000);
    end
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    burst(1, 1'b0, 16'd16, 16'h0, 16'd216, 3);
    burst(1, 1'b0, 16'd15, 16'h0, 16'd215, 3);
    sel = 0;
    burst(1, 1'b0, 16'd3, 16'h0, 16'd103, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
